// File: rtl/div_unit_if.sv
// div_unit request/response handshake bundle.
// The requester drives the master side, the divider implements the slave side.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      operator;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            result_is_zero;

    modport master (
        output in_valid,
        output operator,
        output operand1,
        output operand2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  result_is_zero
    );

    modport slave (
        input  in_valid,
        input  operator,
        input  operand1,
        input  operand2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output result_is_zero
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    div_unit_if.slave  bus
);
    localparam logic [4:0] ALU_OPERATOR_DIV  = 5'd12;
    localparam logic [4:0] ALU_OPERATOR_DIVU = 5'd13;
    localparam logic [4:0] ALU_OPERATOR_REM  = 5'd14;
    localparam logic [4:0] ALU_OPERATOR_REMU = 5'd15;

    localparam logic ALU_RESULT_IS_ZERO     = 1'b1;
    localparam logic ALU_RESULT_IS_NOT_ZERO = 1'b0;

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [4:0]      op_q, op_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            zero_q, zero_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;

    logic            legal;
    logic            is_signed;
    logic            is_div;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            ovf;
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;
    logic            early;

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            op_is_div;
    logic            fix_neg;
    logic [XLEN-1:0] fix_sel;
    logic [XLEN-1:0] fix_val;
    logic            rem_msb_unused;

    // Operator decode of the incoming request.
    always_comb begin
        legal     = 1'b1;
        is_signed = 1'b0;
        is_div    = 1'b0;
        unique case (bus.operator)
            ALU_OPERATOR_DIV: begin
                is_signed = 1'b1;
                is_div    = 1'b1;
            end
            ALU_OPERATOR_DIVU: is_div = 1'b1;
            ALU_OPERATOR_REM:  is_signed = 1'b1;
            ALU_OPERATOR_REMU: is_div = 1'b0;
            default:           legal = 1'b0;
        endcase
    end

    assign sign1    = is_signed & bus.operand1[XLEN-1];
    assign sign2    = is_signed & bus.operand2[XLEN-1];
    assign mag1     = sign1 ? ('0 - bus.operand1) : bus.operand1;
    assign mag2     = sign2 ? ('0 - bus.operand2) : bus.operand2;
    assign div_zero = (bus.operand2 == '0);
    assign ovf      = (bus.operand1 == MIN_NEG) && (bus.operand2 == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    // Results that bypass iteration: illegal op, divide by zero, overflow.
    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        if (!legal) begin
            spec_res = '0;
        end else if (div_zero) begin
            spec_res = is_div ? '1 : bus.operand1;
        end else if (is_signed && ovf) begin
            spec_res = is_div ? MIN_NEG : '0;
        end else begin
            spec_hit = 1'b0;
        end
    end

    assign shifted        = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign trial          = {1'b0, shifted} - {2'b00, dvs_q};
    assign rem_msb_unused = rem_q[XLEN];

    assign op_is_div = (op_q == ALU_OPERATOR_DIV) ||
                       (op_q == ALU_OPERATOR_DIVU);
    assign fix_neg   = op_is_div ? q_neg_q : r_neg_q;
    assign fix_sel   = op_is_div ? quo_q : rem_q[XLEN-1:0];
    assign fix_val   = fix_neg ? ('0 - fix_sel) : fix_sel;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (spec_hit) begin
                            state_d = DONE;
                        end else if (early) begin
                            state_d = FIX;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX:  state_d = DONE;
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.in_ready       = (state_q == IDLE);
        bus.out_valid      = (state_q == DONE);
        bus.result         = res_q;
        bus.result_is_zero = zero_q;
    end

    // Datapath next-state: load at accept, one quotient bit per CALC cycle.
    always_comb begin
        op_d    = op_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        res_d   = res_q;
        zero_d  = zero_q;
        if (!flush) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_d    = bus.operator;
                        dvs_d   = mag2;
                        q_neg_d = sign1 ^ sign2;
                        r_neg_d = sign1;
                        rem_d   = '0;
                        quo_d   = mag1;
                        cnt_d   = CW'(XLEN);
                        if (spec_hit) begin
                            res_d  = spec_res;
                            zero_d = (spec_res == '0) ?
                                     ALU_RESULT_IS_ZERO :
                                     ALU_RESULT_IS_NOT_ZERO;
                        end else if (early) begin
                            rem_d = {1'b0, mag1};
                            quo_d = '0;
                        end
                    end
                end
                CALC: begin
                    if (!trial[XLEN+1]) begin
                        rem_d = trial[XLEN:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end
                FIX: begin
                    res_d  = fix_val;
                    zero_d = (fix_val == '0) ?
                             ALU_RESULT_IS_ZERO :
                             ALU_RESULT_IS_NOT_ZERO;
                end
                DONE: begin
                    res_d = res_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= ALU_RESULT_IS_ZERO;
        end else begin
            op_q    <= op_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider for the execute stage, sits beside the ALU and drives the same result mux.
- Executes the four divide/remainder operators: ALU_OPERATOR_DIV, ALU_OPERATOR_DIVU, ALU_OPERATOR_REM and ALU_OPERATOR_REMU, as defined in define.v.
- Replaces single-cycle division with a 32-step restoring divider behind a valid/ready handshake, so the stage stalls instead of closing timing through a combinational divider.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  clock, rising-edge
- rstn  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous kill of in-flight operation
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept request (high only in IDLE)
- operator  input  5  ALU operator code; only the four divide/remainder codes are legal
- operand1  input  XLEN  dividend
- operand2  input  XLEN  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  quotient or remainder
- result_is_zero  output  1  ALU_RESULT_IS_ZERO when result==0, else ALU_RESULT_IS_NOT_ZERO

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - result_is_zero=ALU_RESULT_IS_ZERO.
  - Internal registers cleared.
  - Reset mid-operation abandons the operation; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, on in_valid && in_ready:
  - Latch the operator.
  - Signed ops (DIV, REM): store |operand1| and |operand2|. Record q_neg = sign1^sign2 and r_neg = sign1.
  - Unsigned ops (DIVU, REMU): store operands as-is, both negate flags 0.
  - Special cases go directly to DONE with the result preloaded:
    - Divisor==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operand1.
    - Signed overflow (operand1==0x80000000, operand2==0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Otherwise: counter=XLEN, go to CALC.
- CALC, one bit per cycle:
  - Shift {rem,quo} left by 1; trial = rem_shifted − divisor.
  - If trial is non-negative: rem = trial, quo[0] = 1. Otherwise rem is kept and quo[0] = 0.
  - Decrement counter; when it reaches 0, go to FIX.
  - Remainder register is XLEN+1 bits so the subtraction carry is captured.
- FIX (1 cycle):
  - Select quotient for DIV/DIVU, remainder for REM/REMU.
  - Negate (two's complement) if q_neg (DIV) or r_neg (REM).
  - Register result and result_is_zero; go to DONE.
- DONE:
  - out_valid=1; result and result_is_zero held stable.
  - On out_ready: go to IDLE and deassert out_valid. in_ready rises the cycle after the handshake; no back-to-back accept.
- Latency (accept edge to out_valid high):
  - Normal: XLEN+2 = 34 cycles.
  - Special cases: 1 cycle.
- flush:
  - Any state → IDLE next edge, out_valid=0; flush overrides a same-cycle out_ready.
  - flush in the same cycle as in_valid in IDLE: request is not accepted.
- Illegal operator at accept: request is accepted, result=0 after the special-case 1-cycle path, no X propagation.
- in_valid while busy is ignored; the upstream holds it until in_ready.
- operand1/operand2 are sampled only at accept; later changes have no effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at accept, if the stored (absolute) dividend < stored divisor and the divisor is non-zero, skip CALC and go to FIX with quotient=0, remainder=dividend. Latency becomes 2 cycles. Sign fix rules are unchanged, e.g. REM −3 % 7 = −3.
- Undefined: these operands take the full 34-cycle path.
- Results must be bit-identical in both builds; only latency differs.

Test Plan:
- DIVU 100/7, out_ready=1 → out_valid exactly 34 cycles after accept, result=14, result_is_zero=NOT_ZERO; REMU same operands → 2.
- DIV −100/7 → 0xFFFFFFF2 (−14); REM −100/7 → 0xFFFFFFFE (−2); DIV 100/−7 → −14; REM 100/−7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, both out_valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM same operands → 0 with result_is_zero=ZERO.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0 throughout; release → IDLE and in_ready=1 next cycle.
- Flush at cycle 15 of CALC, new DIVU 9/3 accepted 2 cycles later → only result 3 appears. Separate run: rstn pulsed low mid-CALC → outputs return to reset values immediately, with no clock edge needed.
- DIVU 3/10 → result 0, REMU 3/10 → 3; latency 2 cycles with DIV_EARLY_OUT_EN defined, 34 without.
